// File: rtl/serial_half_sub_unit_if.sv
// Handshake and result bus of the bit-serial subtractor.
// The master drives the operands and start; the slave returns status, the result and the serial stream.
interface serial_half_sub_unit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             ser_bit;
  logic             ser_valid;

  modport master (
    output start, a_in, b_in,
    input  busy, done, diff, borrow_out, ser_bit, ser_valid
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, diff, borrow_out, ser_bit, ser_valid
  );
endinterface

// File: rtl/serial_half_sub_unit.sv
// Bit-serial subtractor: DIFF = A - B (mod 2^WIDTH), one bit per clock, LSB first.
// A half-subtractor cell feeds a registered borrow; the result shifts in from the MSB end.
module serial_half_sub_unit #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_half_sub_unit_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_out_r;

  logic a0;
  logic b0;
  logic d;
  logic borrow_next;
  logic last_bit;

  // NOTE: every signal written here gets a value on every path, so no latch can be inferred.
  always_comb begin
    a0          = a_sr[0];
    b0          = b_sr[0];
    d           = a0 ^ b0 ^ borrow;
    borrow_next = (~a0 & b0) | (~(a0 ^ b0) & borrow);
    last_bit    = (cnt == CW'(WIDTH - 1));
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      a_sr         <= '0;
      b_sr         <= '0;
      borrow       <= 1'b0;
      cnt          <= '0;
      diff_r       <= '0;
      borrow_out_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_sr   <= bus.a_in;
            b_sr   <= bus.b_in;
            borrow <= 1'b0;
            cnt    <= '0;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          borrow <= borrow_next;
          diff_r <= {d, diff_r[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            borrow_out_r <= borrow_next;
            state        <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // The stream bit is gated so a leftover borrow cannot leak onto ser_bit outside SHIFT.
  assign bus.busy       = (state == S_SHIFT) || (state == S_DONE);
  assign bus.done       = (state == S_DONE);
  assign bus.ser_valid  = (state == S_SHIFT);
  assign bus.ser_bit    = d & (state == S_SHIFT);
  assign bus.diff       = diff_r;
  assign bus.borrow_out = borrow_out_r;

endmodule

// File: tb/tb_serial_half_sub_unit.sv
// Self-checking bench for serial_half_sub_unit: directed corner cases, random operands,
// back-to-back starts with changing operands, and an asynchronous abort.
module tb_serial_half_sub_unit;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_half_sub_unit_if #(.WIDTH(W)) bus ();

  serial_half_sub_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one subtraction from a negedge in IDLE; returns at a negedge with the unit idle again.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] exp_d;
    logic         exp_b;
    logic [W-1:0] ser;
    int           nser;
    int           lat;
    bit           seen;
    exp_d = W'((32'(a) - 32'(b)) % (32'd1 << W));
    exp_b = (a < b);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a_in  = W'($urandom);
    bus.b_in  = W'($urandom);
    ser  = '0;
    nser = 0;
    lat  = -1;
    seen = 1'b0;
    for (int i = 0; i < 3 * W && !seen; i++) begin
      @(negedge clk);
      if (bus.ser_valid) begin
        if (nser < W) ser[nser] = bus.ser_bit;
        nser++;
      end
      if (bus.done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("latency", 32'(lat), 32'(W));
      check("diff", 32'(bus.diff), 32'(exp_d));
      check("borrow_out", 32'(bus.borrow_out), 32'(exp_b));
      check("busy_in_done", 32'(bus.busy), 32'd1);
      check("ser_count", 32'(nser), 32'(W));
      check("ser_bits", 32'(ser), 32'(exp_d));
      @(negedge clk);
      check("done_pulse", 32'(bus.done), 32'd0);
      check("busy_after", 32'(bus.busy), 32'd0);
      check("diff_held", 32'(bus.diff), 32'(exp_d));
    end
  endtask

  logic [W-1:0] ops_a [40];
  logic [W-1:0] ops_b [40];

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    #2;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ser_valid", 32'(bus.ser_valid), 32'd0);
    check("rst_ser_bit", 32'(bus.ser_bit), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_borrow_out", 32'(bus.borrow_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed corner cases, including a borrow rippling through every bit.
    run_op(8'h5A, 8'h23);
    run_op(8'h10, 8'h20);
    run_op(8'hFF, 8'hFF);
    run_op(8'h00, 8'h01);
    run_op(8'h80, 8'h00);
    run_op(8'h00, 8'hFF);

    for (int k = 0; k < 20; k++) begin
      run_op(W'($urandom), W'($urandom));
    end

    // start held high with operands changing every cycle: one accept every W+2 edges.
    for (int c = 0; c < 40; c++) begin
      ops_a[c] = W'($urandom);
      ops_b[c] = W'($urandom);
    end
    for (int c = 0; c < 40; c++) begin
      bus.a_in  = ops_a[c];
      bus.b_in  = ops_b[c];
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (c % (W + 2) == W) begin
        check("stream_done", 32'(bus.done), 32'd1);
        check("stream_diff", 32'(bus.diff), 32'(W'(ops_a[c-W] - ops_b[c-W])));
        check("stream_borrow", 32'(bus.borrow_out), 32'(ops_a[c-W] < ops_b[c-W]));
      end else begin
        check("stream_no_done", 32'(bus.done), 32'd0);
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("stream_idle", 32'(bus.busy), 32'd0);

    // Abort in the middle of a shift sequence.
    bus.a_in  = 8'h5A;
    bus.b_in  = 8'h23;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_ser_valid", 32'(bus.ser_valid), 32'd0);
    check("abort_diff", 32'(bus.diff), 32'd0);
    check("abort_borrow_out", 32'(bus.borrow_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'h05, 8'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
